// File: rtl/video_sync_detect.sv
// rtl/video_sync_detect.sv - VGA sync receiver: measures line/frame timing, locks and classifies mode
//
// Purpose
//   Receives active-low hsync/vsync from an external timing source, re-times them
//   into clk, measures clocks per line, hsync pulse width and lines per frame, and
//   tracks position since the last sync falls. Once frames repeat it asserts locked
//   and classifies the timing as 910 clk/line (mode 0) or 800 clk/line (mode 1).
//
// Ports
//   clk          in   video clock
//   reset_n      in   synchronous reset, active low
//   hsync_in     in   active-low hsync, asynchronous to clk
//   vsync_in     in   active-low vsync, asynchronous to clk
//   hpos         out  clocks since last hsync fall, saturating at 1023
//   vpos         out  hsync falls since last vsync fall, saturating at 1023
//   line_len     out  clocks between the last two hsync falls
//   hs_width     out  clocks hsync was low in the last pulse
//   frame_lines  out  lines in the last full frame
//   new_frame    out  one-clock pulse per detected vsync fall
//   locked       out  timing stable
//   mode         out  0 = 910 clk/line, 1 = 800 clk/line (valid with mode_valid)
//   mode_valid   out  locked and line_len near one of the two known lengths

// Two-flop synchroniser plus one edge-detect stage for one sync pin.
//   clk, reset_n  clock and synchronous active-low reset
//   pin           raw asynchronous input
//   level         synchronised level
//   prev          level delayed by one clock, for edge detection
module video_sync_detect_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic prev
);

  logic meta;

  // Reset to the idle (high) level so leaving reset never fabricates a fall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

endmodule

module video_sync_detect #(
  parameter int TOL         = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [9:0] line_len,
  output logic [9:0] hs_width,
  output logic [9:0] frame_lines,
  output logic       new_frame,
  output logic       locked,
  output logic       mode,
  output logic       mode_valid
);

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  LEN_M0  = 10'd910;
  localparam logic [9:0]  LEN_M1  = 10'd800;
  localparam logic [10:0] TOL_W   = 11'(TOL);
  localparam int          MW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW:0] LOCK_N  = (MW + 1)'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_NOSIG,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  // |a - b| <= TOL, evaluated in 11 bits so the difference never wraps.
  function automatic logic within_tol(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= TOL_W;
  endfunction

  // ---------------------------------------------------------------------------
  // Input re-timing and edge detection
  // ---------------------------------------------------------------------------
  logic hs_level, hs_prev, vs_level, vs_prev;
  logic hfall, hrise, vfall;

  video_sync_detect_sync u_hs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (hsync_in),
    .level   (hs_level),
    .prev    (hs_prev)
  );

  video_sync_detect_sync u_vs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (vsync_in),
    .level   (vs_level),
    .prev    (vs_prev)
  );

  assign hfall = hs_prev & ~hs_level;
  assign hrise = ~hs_prev & hs_level;
  assign vfall = vs_prev & ~vs_level;

  // ---------------------------------------------------------------------------
  // Measurement counters
  // ---------------------------------------------------------------------------
  logic       hpos_sat, vpos_sat, sig_lost;
  logic [9:0] ll_meas;   // line length captured by this hfall
  logic [9:0] fl_meas;   // frame length captured by this vfall
  logic [9:0] ll_now;    // most recent line length including one landing this clock
  logic [9:0] hs_cnt;

  assign hpos_sat = (hpos == CNT_MAX);
  assign vpos_sat = (vpos == CNT_MAX);
  // A saturated position counter means the corresponding sync has vanished.
  assign sig_lost = hpos_sat | vpos_sat;

  assign ll_meas = hpos_sat ? CNT_MAX : hpos + 10'd1;
  // An hfall on the same clock as the vfall still belongs to the ending frame.
  assign fl_meas = (hfall && !vpos_sat) ? vpos + 10'd1 : vpos;
  assign ll_now  = hfall ? ll_meas : line_len;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hpos <= '0;
    end else if (hfall) begin
      hpos <= '0;
    end else if (!hpos_sat) begin
      hpos <= hpos + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vpos <= '0;
    end else if (vfall) begin
      vpos <= '0;
    end else if (hfall && !vpos_sat) begin
      vpos <= vpos + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_cnt <= '0;
    end else if (hrise) begin
      hs_cnt <= '0;
    end else if (!hs_level && hs_cnt != CNT_MAX) begin
      hs_cnt <= hs_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
    end else if (sig_lost) begin
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
    end else begin
      if (hfall) line_len    <= ll_meas;
      if (hrise) hs_width    <= hs_cnt;
      if (vfall) frame_lines <= fl_meas;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      new_frame <= 1'b0;
    end else begin
      new_frame <= vfall;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic          have_full, have_full_nxt;
  logic          prev_valid, prev_valid_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [MW:0]   match_inc;
  logic [9:0]    ref_len, ref_len_nxt;
  logic [9:0]    ref_lines, ref_lines_nxt;
  logic          skip_hchk, skip_nxt;
  logic          lock_lost;

  assign match_inc = {1'b0, match_cnt} + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_NOSIG;
      have_full  <= 1'b0;
      prev_valid <= 1'b0;
      match_cnt  <= '0;
      ref_len    <= '0;
      ref_lines  <= '0;
      skip_hchk  <= 1'b0;
    end else begin
      state      <= state_nxt;
      have_full  <= have_full_nxt;
      prev_valid <= prev_valid_nxt;
      match_cnt  <= match_nxt;
      ref_len    <= ref_len_nxt;
      ref_lines  <= ref_lines_nxt;
      skip_hchk  <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    have_full_nxt  = have_full;
    prev_valid_nxt = prev_valid;
    match_nxt      = match_cnt;
    ref_len_nxt    = ref_len;
    ref_lines_nxt  = ref_lines;
    skip_nxt       = skip_hchk;
    lock_lost      = 1'b0;

    if (sig_lost) begin
      state_nxt      = ST_NOSIG;
      have_full_nxt  = 1'b0;
      prev_valid_nxt = 1'b0;
      match_nxt      = '0;
      ref_len_nxt    = '0;
      ref_lines_nxt  = '0;
      skip_nxt       = 1'b0;
    end else begin
      case (state)
        ST_NOSIG: begin
          // Signal was absent, so the frame ending here is already whole.
          if (vfall) begin
            state_nxt      = ST_ACQUIRE;
            have_full_nxt  = 1'b1;
            prev_valid_nxt = 1'b0;
            match_nxt      = '0;
          end
        end

        ST_ACQUIRE: begin
          if (vfall) begin
            if (!have_full) begin
              // Frame ending here started mid-stream; discard it.
              have_full_nxt = 1'b1;
            end else if (!prev_valid) begin
              ref_len_nxt    = ll_now;
              ref_lines_nxt  = fl_meas;
              prev_valid_nxt = 1'b1;
              match_nxt      = '0;
            end else if (fl_meas == ref_lines && within_tol(ll_now, ref_len)) begin
              match_nxt = match_inc[MW-1:0];
              if (match_inc >= LOCK_N) begin
                state_nxt = ST_LOCKED;
                skip_nxt  = 1'b1;
              end
            end else begin
              ref_len_nxt   = ll_now;
              ref_lines_nxt = fl_meas;
              match_nxt     = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (hfall) begin
            if (skip_hchk) begin
              skip_nxt = 1'b0;
            end else if (!within_tol(ll_meas, ref_len)) begin
              lock_lost = 1'b1;
            end
          end
          if (vfall && fl_meas != ref_lines) begin
            lock_lost = 1'b1;
          end
          if (lock_lost) begin
            state_nxt      = ST_ACQUIRE;
            have_full_nxt  = 1'b0;
            prev_valid_nxt = 1'b0;
            match_nxt      = '0;
            skip_nxt       = 1'b0;
          end
        end

        default: begin
          state_nxt = ST_NOSIG;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, one clock behind the state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked     <= 1'b0;
      mode       <= 1'b0;
      mode_valid <= 1'b0;
    end else begin
      locked     <= (state == ST_LOCKED);
      mode_valid <= (state == ST_LOCKED) &&
                    (within_tol(line_len, LEN_M0) || within_tol(line_len, LEN_M1));
      // Refs are frozen while locked, so mode holds its last decode otherwise.
      if (state == ST_LOCKED) begin
        mode <= within_tol(ref_len, LEN_M1);
      end
    end
  end

endmodule

// File: tb/tb_video_sync_detect.sv
// tb/tb_video_sync_detect.sv - directed scoreboard bench for video_sync_detect
module tb_video_sync_detect;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] hpos, vpos, line_len, hs_width, frame_lines;
  logic       new_frame, locked, mode, mode_valid;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic nf_prev = 1'b0;

  always #5 clk = ~clk;

  video_sync_detect dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_len    (line_len),
    .hs_width    (hs_width),
    .frame_lines (frame_lines),
    .new_frame   (new_frame),
    .locked      (locked),
    .mode        (mode),
    .mode_valid  (mode_valid)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic hs, input logic vs);
    @(negedge clk);
    hsync_in = hs;
    vsync_in = vs;
  endtask

  // vs_line: vsync falls voff clocks into this line and stays low to its end.
  task automatic send_line(input int len, input int hw, input int voff, input bit vs_line);
    for (int c = 0; c < len; c++) begin
      cyc((c < hw) ? 1'b0 : 1'b1, (vs_line && c >= voff) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic send_frame(input int n, input int len, input int hw, input int voff,
                            input int exp_lines);
    exp_q.push_back(exp_lines);
    for (int l = 0; l < n; l++) begin
      send_line(len, hw, voff, l == 0);
    end
  endtask

  // Scoreboard: each vsync fall must pop the expected frame length.
  always @(negedge clk) begin
    if (nf_prev) chk("new_frame_one_clk", {9'd0, new_frame}, 10'd0);
    if (new_frame) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL new_frame_unexpected observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        chk("frame_lines", frame_lines, 10'(exp_q.pop_front()));
        chk("vpos_after_vfall", vpos, 10'd0);
      end
    end
    nf_prev = new_frame;
  end

  initial begin
    reset_n  = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hpos", hpos, 10'd0);
    chk("rst_line_len", line_len, 10'd0);
    chk("rst_hs_width", hs_width, 10'd0);
    chk("rst_frame_lines", frame_lines, 10'd0);
    chk("rst_locked", {9'd0, locked}, 10'd0);
    chk("rst_mode_valid", {9'd0, mode_valid}, 10'd0);
    reset_n = 1'b1;

    // Mode 0 from reset: first frame is partial (one hfall before vfall).
    send_frame(3, 910, 108, 200, 1);
    send_frame(3, 910, 108, 200, 3);
    send_frame(3, 910, 108, 200, 3);
    chk("m0_locked_after_3", {9'd0, locked}, 10'd0);
    send_frame(3, 910, 108, 200, 3);
    chk("m0_locked_after_4", {9'd0, locked}, 10'd1);
    chk("m0_line_len", line_len, 10'd910);
    chk("m0_hs_width", hs_width, 10'd108);
    chk("m0_frame_lines", frame_lines, 10'd3);
    chk("m0_mode", {9'd0, mode}, 10'd0);
    chk("m0_mode_valid", {9'd0, mode_valid}, 10'd1);

    // Jitter inside tolerance keeps lock.
    exp_q.push_back(3);
    send_line(910, 108, 200, 1);
    chk("jit_locked_910", {9'd0, locked}, 10'd1);
    send_line(911, 108, 200, 0);
    chk("jit_locked_911", {9'd0, locked}, 10'd1);
    send_line(909, 108, 200, 0);
    chk("jit_locked_909", {9'd0, locked}, 10'd1);

    // A single 913-clk line is 3 away from 910.
    exp_q.push_back(3);
    send_line(910, 108, 200, 1);
    send_line(913, 108, 200, 0);
    send_line(910, 108, 200, 0);
    chk("jit_913_drop", {9'd0, locked}, 10'd0);
    send_frame(3, 910, 108, 200, 3);
    send_frame(3, 910, 108, 200, 3);
    send_frame(3, 910, 108, 200, 3);
    chk("relock_after_3", {9'd0, locked}, 10'd0);
    send_frame(3, 910, 108, 200, 3);
    chk("relock_after_4", {9'd0, locked}, 10'd1);

    // Switch to mode 1 mid-frame.
    exp_q.push_back(3);
    send_line(910, 108, 200, 1);
    send_line(800, 96, 200, 0);
    send_line(800, 96, 200, 0);
    chk("m1_drop", {9'd0, locked}, 10'd0);
    send_frame(3, 800, 96, 200, 3);
    send_frame(3, 800, 96, 200, 3);
    send_frame(3, 800, 96, 200, 3);
    chk("m1_locked_after_3", {9'd0, locked}, 10'd0);
    send_frame(3, 800, 96, 200, 3);
    chk("m1_locked_after_4", {9'd0, locked}, 10'd1);
    chk("m1_mode", {9'd0, mode}, 10'd1);
    chk("m1_mode_valid", {9'd0, mode_valid}, 10'd1);
    chk("m1_hs_width", hs_width, 10'd96);
    chk("m1_line_len", line_len, 10'd800);

    // One-clock reset mid-frame while locked.
    exp_q.push_back(3);
    send_line(800, 96, 200, 1);
    for (int c = 0; c < 96; c++) cyc(1'b0, 1'b1);
    for (int c = 0; c < 300; c++) cyc(1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_hpos", hpos, 10'd0);
    chk("mid_rst_vpos", vpos, 10'd0);
    chk("mid_rst_line_len", line_len, 10'd0);
    chk("mid_rst_hs_width", hs_width, 10'd0);
    chk("mid_rst_frame_lines", frame_lines, 10'd0);
    chk("mid_rst_new_frame", {9'd0, new_frame}, 10'd0);
    chk("mid_rst_locked", {9'd0, locked}, 10'd0);
    chk("mid_rst_mode", {9'd0, mode}, 10'd0);
    chk("mid_rst_mode_valid", {9'd0, mode_valid}, 10'd0);
    for (int c = 0; c < 402; c++) cyc(1'b1, 1'b1);
    send_line(800, 96, 200, 0);

    // Aligned hsync/vsync falls; first frame after reset holds two hfalls.
    send_frame(3, 910, 108, 0, 2);
    send_frame(3, 910, 108, 0, 3);
    send_frame(3, 910, 108, 0, 3);
    chk("align_locked_after_3", {9'd0, locked}, 10'd0);
    send_frame(3, 910, 108, 0, 3);
    chk("align_locked_after_4", {9'd0, locked}, 10'd1);
    chk("align_frame_lines", frame_lines, 10'd3);
    chk("align_mode", {9'd0, mode}, 10'd0);

    // Hsync disappears after one final fall.
    for (int c = 0; c < 108; c++) cyc(1'b0, 1'b1);
    for (int c = 0; c < 892; c++) cyc(1'b1, 1'b1);
    chk("nosig_still_locked", {9'd0, locked}, 10'd1);
    chk("nosig_line_len_before", line_len, 10'd910);
    for (int c = 0; c < 100; c++) cyc(1'b1, 1'b1);
    chk("nosig_locked", {9'd0, locked}, 10'd0);
    chk("nosig_line_len", line_len, 10'd0);
    chk("nosig_frame_lines", frame_lines, 10'd0);
    chk("nosig_hs_width", hs_width, 10'd0);
    chk("nosig_mode_valid", {9'd0, mode_valid}, 10'd0);
    chk("nosig_hpos_sat", hpos, 10'd1023);

    chk("scoreboard_empty", 10'(exp_q.size()), 10'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
